bfly_merge_1024: RTL
====================

# bfly_merge_1024

Re-serializer at the output of a radix-2 butterfly. It is the counterpart of the stage-input delay FIFO that splits one serial stream into an (x1, x2) pair. Each valid cycle it takes a butterfly result pair (y1, y2), forwards y1 immediately, and parks y2 in an internal buffer. After a full frame of `depth` pairs it drains the parked y2 values back-to-back, so the next stage sees one serial complex stream in natural SDF order.

## Interface
- `float_len`, 32: width of one float; a complex sample is `2*float_len` bits, {real, imag}.
- `depth`, 1024: pairs per frame, which is the number of y2 samples buffered.
- `addr_len`, 10: buffer address width; 2^addr_len == depth.
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `data_in1` input 2*float_len: butterfly output y1.
- `data_in2` input 2*float_len: butterfly output y2.
- `data_in_valid` input 1: the pair is valid this cycle. There is no backpressure.
- `data_out` output 2*float_len: serial output sample.
- `data_out_valid` output 1: `data_out` is valid.
- `data_out_last` output 1: high with the final drained y2 of a frame.
- `overrun` output 1: sticky flag, set when a pair arrives during DRAIN.

## Operation
- State machine, states FILL and DRAIN. Reset state is FILL. Counters `wr_cnt` and `rd_cnt` are `addr_len` bits and reset to 0.
- FILL, with `data_in_valid`=1:
  - write `data_in2` to buffer[`wr_cnt`];
  - register `data_in1` to `data_out` with `data_out_valid`=1;
  - increment `wr_cnt`.
- FILL transition: when the pair accepted has `wr_cnt`==depth-1, `wr_cnt` wraps to 0 and the state becomes DRAIN on the next cycle.
- DRAIN, every cycle regardless of input:
  - issue a buffer read at `rd_cnt` and increment `rd_cnt`;
  - on the read with `rd_cnt`==depth-1, `rd_cnt` wraps to 0 and the state returns to FILL.
- Buffer read data is registered once more into `data_out`, with `data_out_valid`=1. `data_out_last`=1 only for index depth-1.
- Pairs arriving in DRAIN:
  - the pair is dropped;
  - the buffer and counters are unaffected;
  - `overrun` is set and stays set until `rst`.
- Output source mux:
  - the registered y1 path when a pair was accepted in the previous cycle;
  - otherwise the buffer read path when a read was issued in the previous cycle;
  - otherwise `data_out_valid`=0 and `data_out` holds its last value.
  - The two paths can never both be active in one cycle.
- No arithmetic is performed. Data passes bit-exact.

## Timing
- Reset values: `data_out`=0, `data_out_valid`=0, `data_out_last`=0, `overrun`=0, state FILL, both counters 0. Buffer contents are not cleared.
- y1 latency is 1 cycle: a pair accepted at cycle c gives y1 on `data_out` at c+1.
- If the last pair of a frame is accepted at cycle t:
  - y1 of that pair appears at t+1;
  - reads are issued at t+1 .. t+depth;
  - y2[0..depth-1] appear at t+2 .. t+depth+1 with no gap;
  - `data_out_last` is high at t+depth+1.
- A pair is accepted again from cycle t+depth+1 onward, and its y1 appears at t+depth+2.
- Valid pairs within a frame may have gaps. Output y1s follow the same gaps, and the drain starts only after the depth-th pair.
- `rst` mid-frame or mid-drain: all outputs and counters return to reset values immediately. Any partial frame is discarded, and the next valid pair is index 0 of a new frame.

## Structure
- Shared package (with the other FFT stages): `float_len` and the complex-sample width constant.
- Sub-module `sdp_ram`: simple dual-port, one write port and one registered read port, width 2*float_len, depth 2^addr_len, no reset on the array. It must infer block RAM.
- The top level contains the state machine, the two counters, the output mux and the overrun flag.

## Test plan
- depth=4, 4 consecutive pairs (y1,y2)=(10,20),(11,21),(12,22),(13,23) -> `data_out` 10,11,12,13,20,21,22,23 on 8 consecutive cycles starting 1 cycle after the first pair; `data_out_last` only on 23.
- depth=4, pairs with idle gaps (valid pattern 1,0,1,1,0,1) -> y1s 10,11,12,13 follow the gaps; drain 20..23 starts the cycle after 13 with no gap.
- depth=4, valid held high for 10 cycles -> pairs 5–8 (during DRAIN) are dropped and `overrun`=1. The stream is 10..13,20..23; pairs 9–10 then start frame 2 and give outputs 18,19.
- Assert `rst` during DRAIN after 2 of 4 stored y2 are output -> `data_out_valid` drops immediately. A new 4-pair frame (30..33,40..43) outputs 30..33,40..43 exactly.
- depth=1024, two back-to-back frames of incrementing data -> 2048 outputs per frame in correct order and `overrun`=0.
- Reset release: no input for 20 cycles -> `data_out_valid`, `data_out_last` and `overrun` stay 0 and `data_out`=0.

Source files
------------

// File: rtl/bfly_merge_1024_pkg.sv
// Shared FFT-stage constants and types for the butterfly output re-serializer.
package bfly_merge_1024_pkg;

  localparam int unsigned FLOAT_LEN = 32;
  localparam int unsigned CPLX_W    = 2 * FLOAT_LEN;

  // One complex sample, {real, imag}.
  typedef struct packed {
    logic [FLOAT_LEN-1:0] re;
    logic [FLOAT_LEN-1:0] im;
  } cplx_t;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/bfly_merge_1024_if.sv
// Butterfly pair input / serial output bundle for bfly_merge_1024.
interface bfly_merge_1024_if;
  import bfly_merge_1024_pkg::*;

  cplx_t data_in1;
  cplx_t data_in2;
  logic  data_in_valid;
  cplx_t data_out;
  logic  data_out_valid;
  logic  data_out_last;
  logic  overrun;

  modport master (
    output data_in1, data_in2, data_in_valid,
    input  data_out, data_out_valid, data_out_last, overrun
  );

  modport slave (
    input  data_in1, data_in2, data_in_valid,
    output data_out, data_out_valid, data_out_last, overrun
  );

endinterface

// File: rtl/bfly_merge_1024_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no array reset.
module sdp_ram
  import bfly_merge_1024_pkg::*;
#(
  parameter int unsigned addr_len = 10
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [addr_len-1:0] waddr_i,
  input  logic [CPLX_W-1:0]   wdata_i,
  input  logic                re_i,
  input  logic [addr_len-1:0] raddr_i,
  output logic [CPLX_W-1:0]   rdata_o
);

  localparam int unsigned depth = 32'(1) << addr_len;

  logic [CPLX_W-1:0] mem_q [depth];
  logic [CPLX_W-1:0] rdata_q;

  // Write and registered read; kept reset-free so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bfly_merge_1024.sv
// Re-serializes butterfly (y1, y2) pairs: y1 passes straight through, a frame of
// y2 values is parked in RAM and drained back-to-back once the frame is complete.
module bfly_merge_1024
  import bfly_merge_1024_pkg::*;
#(
  parameter int unsigned addr_len = 10
) (
  input logic              clk,
  input logic              rst,
  bfly_merge_1024_if.slave bus
);

  localparam int unsigned         depth    = 32'(1) << addr_len;
  localparam logic [addr_len-1:0] LAST_IDX = addr_len'(depth - 1);

  state_e              state_q, state_d;
  logic [addr_len-1:0] wr_cnt_q, wr_cnt_d;
  logic [addr_len-1:0] rd_cnt_q, rd_cnt_d;
  cplx_t               data_out_q, data_out_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                overrun_q, overrun_d;
  logic                accept_c;
  logic                ram_re_c;
  logic [CPLX_W-1:0]   ram_rdata;

  // The RAM read is issued one edge ahead (at the next rd_cnt) so that the
  // registered read data is ready when the DRAIN cycle for that index loads
  // data_out; this keeps y1 -> y2 output gap-free.
  sdp_ram #(.addr_len(addr_len)) u_ram (
    .clk     (clk),
    .we_i    (accept_c),
    .waddr_i (wr_cnt_q),
    .wdata_i (bus.data_in2),
    .re_i    (ram_re_c),
    .raddr_i (rd_cnt_d),
    .rdata_o (ram_rdata)
  );

  // Next-state, counter and output-mux logic.
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    overrun_d  = overrun_q;
    accept_c   = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (bus.data_in_valid) begin
          accept_c   = 1'b1;
          wr_cnt_d   = wr_cnt_q + addr_len'(1);
          data_out_d = bus.data_in1;
          valid_d    = 1'b1;
          if (wr_cnt_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        rd_cnt_d   = rd_cnt_q + addr_len'(1);
        data_out_d = ram_rdata;
        valid_d    = 1'b1;
        last_d     = (rd_cnt_q == LAST_IDX);
        if (rd_cnt_q == LAST_IDX) begin
          state_d = ST_FILL;
        end
        // Pairs arriving while draining are dropped and flagged.
        if (bus.data_in_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
    ram_re_c = (state_d == ST_DRAIN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FILL;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = valid_q;
  assign bus.data_out_last  = last_q;
  assign bus.overrun        = overrun_q;

endmodule
